blob_engine: RTL and testbench

Parametrised multi-sprite engine that replaces a hand-instantiated array of single blobs. It holds NR_OF_BLOBS rectangle descriptors behind a register write port, double-buffered per frame. Each 25 MHz pixel strobe it resolves which enabled sprite covers the current screen position, picking by layer priority. It emits one RAM read request (address, layer, blob id) toward the pixel memory/arbiter path, and sits between the sync generator and the pixel RAM.

---
 rtl/blob_pkg.sv | 35 +++
 rtl/blob_channel.sv | 109 ++++++++++
 rtl/blob_engine.sv | 141 ++++++++++++++
 tb/tb_blob_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// ----------------------------------------------------------------------------
// blob_pkg: shared register map, sprite descriptor type and screen defaults
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package blob_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;

  localparam int CFG_POS_WIDTH   = 10;
  localparam int CFG_ADD_WIDTH   = 16;
  localparam int CFG_LAYER_WIDTH = 2;

  localparam logic [2:0] REG_X1   = 3'd0;
  localparam logic [2:0] REG_Y1   = 3'd1;
  localparam logic [2:0] REG_X2   = 3'd2;
  localparam logic [2:0] REG_Y2   = 3'd3;
  localparam logic [2:0] REG_BASE = 3'd4;
  localparam logic [2:0] REG_CTRL = 3'd5;

  typedef struct packed {
    logic [CFG_POS_WIDTH-1:0]   x1;
    logic [CFG_POS_WIDTH-1:0]   y1;
    logic [CFG_POS_WIDTH-1:0]   x2;
    logic [CFG_POS_WIDTH-1:0]   y2;
    logic [CFG_ADD_WIDTH-1:0]   base;
    logic [CFG_LAYER_WIDTH-1:0] layer;
    logic                       flip_x;
    logic                       enable;
  } blob_cfg_t;

endpackage

`default_nettype wire

// File: rtl/blob_channel.sv
// ----------------------------------------------------------------------------
// blob_channel: one sprite's shadow/active config, row base and stage-1 hit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module blob_channel
  import blob_pkg::*;
#(
  parameter int ADD_WIDTH   = CFG_ADD_WIDTH,
  parameter int POS_WIDTH   = CFG_POS_WIDTH,
  parameter int LAYER_WIDTH = CFG_LAYER_WIDTH,
  parameter int H_ACTIVE    = H_ACTIVE_DEFAULT,
  parameter int DATA_WIDTH  = CFG_ADD_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk25en,
  input  logic                   frame_start,
  input  logic                   blank,
  input  logic [POS_WIDTH-1:0]   x,
  input  logic [POS_WIDTH-1:0]   y,
  input  logic                   wr_en,
  input  logic [2:0]             reg_addr,
  input  logic [DATA_WIDTH-1:0]  reg_data,
  output logic                   hit,
  output logic [ADD_WIDTH-1:0]   address,
  output logic [LAYER_WIDTH-1:0] layer
);

  blob_cfg_t shadow_q, shadow_d, active_q, active_d;
  logic [ADD_WIDTH-1:0]   row_base_q, row_base_d, base_now;
  logic                   hit_q, hit_d;
  logic [ADD_WIDTH-1:0]   addr_q, addr_d;
  logic [LAYER_WIDTH-1:0] layer_q, layer_d;
  logic [POS_WIDTH-1:0]   x1, y1, x2, y2, offset;
  logic                   in_x, in_y, geom_ok;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      case (reg_addr)
        REG_X1:   shadow_d.x1   = CFG_POS_WIDTH'(reg_data);
        REG_Y1:   shadow_d.y1   = CFG_POS_WIDTH'(reg_data);
        REG_X2:   shadow_d.x2   = CFG_POS_WIDTH'(reg_data);
        REG_Y2:   shadow_d.y2   = CFG_POS_WIDTH'(reg_data);
        REG_BASE: shadow_d.base = CFG_ADD_WIDTH'(reg_data);
        REG_CTRL: begin
          shadow_d.enable = reg_data[0];
          shadow_d.layer  = CFG_LAYER_WIDTH'(reg_data[LAYER_WIDTH:1]);
          shadow_d.flip_x = reg_data[LAYER_WIDTH+1];
        end
        default: ;
      endcase
    end

    // The frame-start pixel already uses the freshly latched descriptor.
    active_d = frame_start ? shadow_q : active_q;
    base_now = frame_start ? ADD_WIDTH'(shadow_q.base) : row_base_q;

    x1 = POS_WIDTH'(active_d.x1);
    y1 = POS_WIDTH'(active_d.y1);
    x2 = POS_WIDTH'(active_d.x2);
    y2 = POS_WIDTH'(active_d.y2);

    geom_ok = (x1 <= x2) && (y1 <= y2);
    in_x    = (x >= x1) && (x <= x2);
    in_y    = (y >= y1) && (y <= y2);
    offset  = active_d.flip_x ? (x2 - x) : (x - x1);

    row_base_d = base_now;
    if (clk25en && !frame_start && (x == POS_WIDTH'(H_ACTIVE - 1)) && in_y && geom_ok)
      row_base_d = row_base_q + ADD_WIDTH'(x2 - x1) + ADD_WIDTH'(1);

    hit_d   = hit_q;
    addr_d  = addr_q;
    layer_d = layer_q;
    if (clk25en && !blank) begin
      hit_d   = active_d.enable && in_x && in_y;
      addr_d  = base_now + ADD_WIDTH'(offset);
      layer_d = LAYER_WIDTH'(active_d.layer);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q   <= '0;
      active_q   <= '0;
      row_base_q <= '0;
      hit_q      <= 1'b0;
      addr_q     <= '0;
      layer_q    <= '0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      row_base_q <= row_base_d;
      hit_q      <= hit_d;
      addr_q     <= addr_d;
      layer_q    <= layer_d;
    end
  end

  assign hit     = hit_q;
  assign address = addr_q;
  assign layer   = layer_q;

endmodule

`default_nettype wire

// File: rtl/blob_engine.sv
// ----------------------------------------------------------------------------
// blob_engine: multi-sprite layer-priority resolver issuing pixel RAM requests
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module blob_engine
  import blob_pkg::*;
#(
  parameter int NR_OF_BLOBS = 4,
  parameter int ADD_WIDTH   = 16,
  parameter int POS_WIDTH   = 10,
  parameter int LAYER_WIDTH = 2,
  parameter int H_ACTIVE    = H_ACTIVE_DEFAULT,
  localparam int SEL_WIDTH  = (NR_OF_BLOBS > 1) ? $clog2(NR_OF_BLOBS) : 1,
  localparam int DATA_WIDTH = (ADD_WIDTH > POS_WIDTH) ? ADD_WIDTH : POS_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk25en,
  input  logic [POS_WIDTH-1:0]   curr_x_pos,
  input  logic [POS_WIDTH-1:0]   curr_y_pos,
  input  logic                   blank,
  input  logic                   reg_wr,
  input  logic [SEL_WIDTH-1:0]   reg_sel,
  input  logic [2:0]             reg_addr,
  input  logic [DATA_WIDTH-1:0]  reg_data,
  output logic                   pix_valid,
  output logic                   hit,
  output logic                   request,
  output logic [ADD_WIDTH-1:0]   address,
  output logic [LAYER_WIDTH-1:0] layer,
  output logic [SEL_WIDTH-1:0]   blob_id
);

  logic                   frame_start;
  logic                   hit_s1   [NR_OF_BLOBS];
  logic [ADD_WIDTH-1:0]   addr_s1  [NR_OF_BLOBS];
  logic [LAYER_WIDTH-1:0] layer_s1 [NR_OF_BLOBS];

  assign frame_start = clk25en && (curr_x_pos == '0) && (curr_y_pos == '0);

  for (genvar g = 0; g < NR_OF_BLOBS; g++) begin : g_blob
    blob_channel #(
      .ADD_WIDTH   (ADD_WIDTH),
      .POS_WIDTH   (POS_WIDTH),
      .LAYER_WIDTH (LAYER_WIDTH),
      .H_ACTIVE    (H_ACTIVE),
      .DATA_WIDTH  (DATA_WIDTH)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .clk25en     (clk25en),
      .frame_start (frame_start),
      .blank       (blank),
      .x           (curr_x_pos),
      .y           (curr_y_pos),
      .wr_en       (reg_wr && (reg_sel == SEL_WIDTH'(g))),
      .reg_addr    (reg_addr),
      .reg_data    (reg_data),
      .hit         (hit_s1[g]),
      .address     (addr_s1[g]),
      .layer       (layer_s1[g])
    );
  end

  logic                   s1_valid_q, s1_valid_d;
  logic                   win_hit;
  logic [ADD_WIDTH-1:0]   win_addr;
  logic [LAYER_WIDTH-1:0] win_layer;
  logic [SEL_WIDTH-1:0]   win_id;

  // Strictly-greater compare keeps the lowest index on a layer tie.
  always_comb begin
    win_hit   = 1'b0;
    win_addr  = '0;
    win_layer = '0;
    win_id    = '0;
    for (int i = 0; i < NR_OF_BLOBS; i++) begin
      if (hit_s1[i] && (!win_hit || (layer_s1[i] > win_layer))) begin
        win_hit   = 1'b1;
        win_addr  = addr_s1[i];
        win_layer = layer_s1[i];
        win_id    = SEL_WIDTH'(i);
      end
    end
  end

  logic                   pix_valid_q, pix_valid_d;
  logic                   hit_q, hit_d;
  logic                   request_q, request_d;
  logic [ADD_WIDTH-1:0]   address_q, address_d;
  logic [LAYER_WIDTH-1:0] layer_q, layer_d;
  logic [SEL_WIDTH-1:0]   blob_id_q, blob_id_d;

  always_comb begin
    s1_valid_d  = clk25en && !blank;
    pix_valid_d = s1_valid_q;
    request_d   = s1_valid_q && win_hit;
    hit_d       = hit_q;
    address_d   = address_q;
    layer_d     = layer_q;
    blob_id_d   = blob_id_q;
    if (s1_valid_q) begin
      hit_d     = win_hit;
      address_d = win_addr;
      layer_d   = win_layer;
      blob_id_d = win_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      request_q   <= 1'b0;
      address_q   <= '0;
      layer_q     <= '0;
      blob_id_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      pix_valid_q <= pix_valid_d;
      hit_q       <= hit_d;
      request_q   <= request_d;
      address_q   <= address_d;
      layer_q     <= layer_d;
      blob_id_q   <= blob_id_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign hit       = hit_q;
  assign request   = request_q;
  assign address   = address_q;
  assign layer     = layer_q;
  assign blob_id   = blob_id_q;

endmodule

`default_nettype wire

// File: tb/tb_blob_engine.sv
// ----------------------------------------------------------------------------
// tb_blob_engine: scoreboard bench driving directed pixel strobes and writes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_blob_engine;

  localparam logic [2:0] A_X1 = 3'd0, A_Y1 = 3'd1, A_X2 = 3'd2, A_Y2 = 3'd3;
  localparam logic [2:0] A_BASE = 3'd4, A_CTRL = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk25en = 1'b0;
  logic [9:0]  curr_x_pos = '0, curr_y_pos = '0;
  logic        blank = 1'b0;
  logic        reg_wr = 1'b0;
  logic [1:0]  reg_sel = '0;
  logic [2:0]  reg_addr = '0;
  logic [15:0] reg_data = '0;
  logic        pix_valid, hit, request;
  logic [15:0] address;
  logic [1:0]  layer, blob_id;

  blob_engine dut (
    .clk(clk), .reset(reset), .clk25en(clk25en),
    .curr_x_pos(curr_x_pos), .curr_y_pos(curr_y_pos), .blank(blank),
    .reg_wr(reg_wr), .reg_sel(reg_sel), .reg_addr(reg_addr), .reg_data(reg_data),
    .pix_valid(pix_valid), .hit(hit), .request(request),
    .address(address), .layer(layer), .blob_id(blob_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x; int y; int hit; int addr; int layer; int id; int cyc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int failed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per pix_valid pulse.
  always @(negedge clk) begin
    if (pix_valid) begin
      if (q.size() == 0) begin
        tests++; failed++;
        $display("FAIL stray_pix_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("latency(%0d,%0d)", e.x, e.y), cyc - e.cyc, 2);
        chk($sformatf("hit(%0d,%0d)", e.x, e.y), int'(hit), e.hit);
        chk($sformatf("request(%0d,%0d)", e.x, e.y), int'(request), e.hit);
        chk($sformatf("address(%0d,%0d)", e.x, e.y), int'(address), e.addr);
        chk($sformatf("layer(%0d,%0d)", e.x, e.y), int'(layer), e.layer);
        chk($sformatf("blob_id(%0d,%0d)", e.x, e.y), int'(blob_id), e.id);
      end
    end else if (request) begin
      tests++; failed++;
      $display("FAIL stray_request: got 1 expected 0 at cycle %0d", cyc);
    end
  end

  task automatic wr(input int sel, input logic [2:0] a, input int d);
    @(posedge clk); #1;
    reg_wr = 1'b1; reg_sel = 2'(sel); reg_addr = a; reg_data = 16'(d);
    @(posedge clk); #1;
    reg_wr = 1'b0;
  endtask

  task automatic set_blob(input int sel, input int x1, input int y1, input int x2,
                          input int y2, input int base, input int ctrl);
    wr(sel, A_X1, x1); wr(sel, A_Y1, y1); wr(sel, A_X2, x2);
    wr(sel, A_Y2, y2); wr(sel, A_BASE, base); wr(sel, A_CTRL, ctrl);
  endtask

  // One pixel strobe followed by three idle clk cycles; optional coincident write.
  task automatic px(input int x, input int y, input int eh, input int ea = 0,
                    input int el = 0, input int eid = 0, input bit bl = 1'b0,
                    input bit w = 1'b0, input logic [2:0] wa = 3'd0, input int wd = 0);
    @(posedge clk); #1;
    curr_x_pos = 10'(x); curr_y_pos = 10'(y); blank = bl; clk25en = 1'b1;
    if (w) begin
      reg_wr = 1'b1; reg_sel = 2'd0; reg_addr = wa; reg_data = 16'(wd);
    end
    if (!bl) q.push_back('{x, y, eh, ea, el, eid, cyc});
    @(posedge clk); #1;
    clk25en = 1'b0; reg_wr = 1'b0; blank = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_request", int'(request), 0);
    chk("rst_address", int'(address), 0);
    reset = 1'b0;

    // Basic rectangle with line-end row_base advance
    set_blob(0, 3, 5, 6, 7, 50, 7);
    px(0, 0, 0);
    px(3, 5, 1, 50, 3, 0);
    px(6, 5, 1, 53, 3, 0);
    px(7, 5, 0);
    px(5, 5, 0, 0, 0, 0, 1'b1);
    px(639, 5, 0);
    px(3, 6, 1, 54, 3, 0);
    px(639, 6, 0);
    px(6, 7, 1, 61, 3, 0);

    // Horizontal flip
    wr(0, A_CTRL, 15);
    px(0, 0, 0);
    px(3, 5, 1, 53, 3, 0);
    px(639, 5, 0);
    px(6, 6, 1, 54, 3, 0);

    // Layer priority, then a layer tie
    wr(0, A_CTRL, 7);
    set_blob(2, 3, 5, 6, 7, 100, 3);
    px(0, 0, 0);
    px(4, 5, 1, 51, 3, 0);
    wr(0, A_CTRL, 5);
    wr(2, A_CTRL, 5);
    px(0, 0, 0);
    px(4, 5, 1, 51, 2, 0);

    // Mid-frame writes wait for the next frame
    wr(0, A_CTRL, 7);
    wr(2, A_CTRL, 0);
    px(0, 0, 0);
    px(3, 5, 1, 50, 3, 0);
    wr(0, A_X1, 10);
    wr(0, A_X2, 13);
    px(3, 5, 1, 50, 3, 0);
    px(4, 5, 1, 51, 3, 0);
    px(0, 0, 0);
    px(3, 5, 0);
    px(10, 5, 1, 50, 3, 0);

    // Write coinciding with frame start applies one frame later
    px(0, 0, 0, 0, 0, 0, 1'b0, 1'b1, A_BASE, 200);
    px(10, 5, 1, 50, 3, 0);
    px(0, 0, 0);
    px(10, 5, 1, 200, 3, 0);

    // Degenerate rectangle: no hits, row_base frozen
    wr(0, A_X1, 20);
    px(0, 0, 0);
    px(15, 5, 0);
    px(20, 5, 0);
    px(639, 5, 0);
    px(639, 6, 0);
    chk("row_base_frozen", int'(dut.g_blob[0].u_chan.row_base_q), 200);

    // Asynchronous reset while request is high
    wr(0, A_X1, 10);
    px(0, 0, 0);
    @(posedge clk); #1;
    curr_x_pos = 10'd10; curr_y_pos = 10'd5; clk25en = 1'b1;
    q.push_back('{10, 5, 1, 200, 3, 0, cyc});
    @(posedge clk); #1;
    clk25en = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    chk("req_before_rst", int'(request), 1);
    reset = 1'b1;
    #1;
    chk("rst_async_request", int'(request), 0);
    chk("rst_async_hit", int'(hit), 0);
    chk("rst_async_address", int'(address), 0);
    chk("rst_async_layer", int'(layer), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    px(0, 0, 0);
    px(10, 5, 0);
    set_blob(0, 3, 5, 6, 7, 50, 7);
    px(3, 5, 0);
    px(0, 0, 0);
    px(3, 5, 1, 50, 3, 0);

    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    chk("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
